// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter width helper for serial_adder
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} sa_state_t;
   // Bit counter width; it only has to reach WIDTH-1.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction
endpackage

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: combinational 1-bit full adder from two half-adder cells plus OR
//   a_i, b_i, c_i : addend bits and carry-in
//   s_o, c_o      : sum bit and carry-out
module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   logic hs, hc, hc2;
   assign hs  = a_i ^ b_i;
   assign hc  = a_i & b_i;
   assign s_o = hs ^ c_i;
   assign hc2 = hs & c_i;
   assign c_o = hc | hc2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock
//   clk, rst (async, active-high)
//   start_valid/start_ready, a, b, cin : operand handshake, accepted in IDLE only
//   res_valid/res_ready, sum, cout     : result handshake, held in DONE
//   busy                               : high while bits are being added
//   ovf                                : signed overflow, present only with SERIAL_ADDER_OVF_EN
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = cnt_w(WIDTH);
   sa_state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic carry_q, carry_d, cout_q, cout_d, fs, fc;
   logic [WIDTH-1:0] sr_next;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
`endif
   serial_adder_fa u_fa (
      .a_i(a_q[0]),
      .b_i(b_q[0]),
      .c_i(carry_q),
      .s_o(fs),
      .c_o(fc)
   );
   assign sr_next = {fs, sr_q[WIDTH-1:1]};
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: if (start_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sr_d    = sr_next;
            carry_d = fc;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = sr_next;
               cout_d  = fc;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB on this last bit
               ovf_d   = carry_q ^ fc;
`endif
               state_d = DONE;
            end
         end
         DONE: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end
   // Gate with rst so ready is low while reset is held, not just after it.
   assign start_ready = (state_q == IDLE) & ~rst;
   assign res_valid   = state_q == DONE;
   assign busy        = state_q == RUN;
   assign sum         = sum_q;
   assign cout        = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf         = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
   localparam int WIDTH = 8;
   logic clk = 1'b0;
   logic rst, start_valid, start_ready, cin, res_valid, res_ready, cout, busy;
   logic [WIDTH-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf;
`endif
   int n_chk = 0;
   int n_fail = 0;
   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .sum(sum),
      .cout(cout),
      .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf(ovf)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One complete operation; caller is at a negedge with the DUT idle.
   task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                        input int stall, input logic sv_hold);
      logic [WIDTH:0] full;
      int lat, busy_n;
`ifdef SERIAL_ADDER_OVF_EN
      int s;
      logic eovf;
      s = int'($signed(oa)) + int'($signed(ob)) + int'(oc);
      eovf = (s > 2 ** (WIDTH - 1) - 1) || (s < -(2 ** (WIDTH - 1)));
`endif
      full = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, oc};
      start_valid = 1'b1;
      a = oa;
      b = ob;
      cin = oc;
      lat = 0;
      while (!start_ready && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("accept_ready", 64'(start_ready), 64'(1));
      @(posedge clk);
      #1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      start_valid = sv_hold;
      busy_n = 0;
      lat = 0;
      @(negedge clk);
      while (!res_valid && lat < WIDTH + 4) begin
         busy_n += int'(busy);
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'(WIDTH));
      chk("busy_cycles", 64'(busy_n), 64'(WIDTH));
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", 64'(res_valid), 64'(1));
         chk("stall_ready", 64'(start_ready), 64'(0));
         chk("stall_sum", 64'(sum), 64'(full[WIDTH-1:0]));
         chk("stall_cout", 64'(cout), 64'(full[WIDTH]));
         @(negedge clk);
      end
      chk("res_valid", 64'(res_valid), 64'(1));
      chk("sum", 64'(sum), 64'(full[WIDTH-1:0]));
      chk("cout", 64'(cout), 64'(full[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 64'(ovf), 64'(eovf));
`endif
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'($urandom);
      @(negedge clk);
      start_valid = 1'b0;
      chk("post_valid", 64'(res_valid), 64'(0));
      chk("post_busy", 64'(busy), 64'(0));
      chk("post_ready", 64'(start_ready), 64'(1));
      chk("hold_sum", 64'(sum), 64'(full[WIDTH-1:0]));
      res_ready = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      start_valid = 1'b1;
      res_ready = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_start_ready", 64'(start_ready), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'(0));
`endif
      rst = 1'b0;
      start_valid = 1'b0;
      @(negedge clk);
      chk("rel_start_ready", 64'(start_ready), 64'(1));
      chk("rel_res_valid", 64'(res_valid), 64'(0));
      chk("rel_sum", 64'(sum), 64'(0));
      chk("rel_cout", 64'(cout), 64'(0));
      do_op(WIDTH'('h3C), WIDTH'('h05), 1'b0, 0, 1'b0);
      do_op(WIDTH'('hFF), WIDTH'('h01), 1'b0, 1, 1'b0);
      do_op(WIDTH'('h7F), WIDTH'('h01), 1'b0, 0, 1'b0);
      do_op(WIDTH'('hFF), WIDTH'('hFF), 1'b1, 2, 1'b0);
      do_op(WIDTH'('h5A), WIDTH'('hC3), 1'b1, 5, 1'b1);
      // Abort mid-operation: reset after 3 RUN cycles must leave no result behind.
      start_valid = 1'b1;
      a = WIDTH'('hAA);
      b = WIDTH'('h55);
      cin = 1'b0;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_abort_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_valid", 64'(res_valid), 64'(0));
      chk("abort_ready", 64'(start_ready), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < WIDTH + 3; i++) begin
         @(negedge clk);
         chk("abort_no_result", 64'(res_valid), 64'(0));
         chk("abort_idle", 64'(start_ready), 64'(1));
      end
      do_op(WIDTH'('h12), WIDTH'('h34), 1'b0, 0, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
